fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the 5-stage pipeline: owns the PC, drives the instruction-memory request port, and drives the IF/ID pipeline register consumed by decode. It sits directly upstream of the load-use hazard unit and obeys that unit's `writePc` / `writeIfId` stall outputs. It absorbs variable instruction-memory latency, flushes on branch/jump redirect, and stops on HALT.

## Interface
- `RESET_PC`, default 16'h0000: PC loaded on reset.
- `NOP_INSTR`, default 16'h0800: bubble instruction placed in IF/ID on reset or flush.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `writePc` in 1: 0 = hold PC (from hazard unit).
- `writeIfId` in 1: 0 = hold IF/ID (from hazard unit).
- `redirect` in 1: resolved taken branch/jump; flush and refetch.
- `redirectPc` in 16: redirect target; bit 0 forced to 0.
- `haltId` in 1: decode holds HALT; stop fetching.
- `imemReq` out 1: request valid, address = `imemAddr`.
- `imemAddr` out 16: current PC.
- `imemDone` in 1: response valid this cycle.
- `imemRdata` in 16: instruction, valid with `imemDone`.
- `instrIfId` out 16: IF/ID instruction.
- `pcPlus2IfId` out 16: IF/ID PC+2.
- `validIfId` out 1: IF/ID holds a real instruction.

## Operation
- Stall = `!writePc | !writeIfId`. An instruction is available when `imemDone` is high in REQ/WAIT, or the buffer is full in BUF.
- States: REQ (reset state), WAIT, BUF, DRAIN, HALTED. One outstanding request maximum.
- REQ: `imemReq`=1. If `imemDone` and not stalled: load IF/ID {rdata, pc+2, 1}, pc += 2, stay REQ. If `imemDone` and stalled: capture rdata into the buffer, go BUF. If no `imemDone`: go WAIT.
- WAIT: `imemReq`=0. On `imemDone`, behave as REQ on done.
- BUF: `imemReq`=0. On not stalled: load IF/ID from the buffer, pc += 2, go REQ.
- DRAIN: `imemReq`=0. On `imemDone`: discard the response, go REQ.
- HALTED: `imemReq`=0. IF/ID holds bubble. Stays here until redirect or reset.
- IF/ID write rule: IF/ID holds its value whenever stalled. Otherwise, with no instruction available, it loads a bubble ({`NOP_INSTR`, hold pcPlus2, 0}).
- Redirect has highest priority and overrides stall.
  - pc <= {redirectPc[15:1],0}.
  - IF/ID <= bubble.
  - Buffer dropped.
  - Next state: DRAIN if a request is in flight with no `imemDone` this cycle (REQ without done, or WAIT without done); otherwise REQ. This includes from BUF and HALTED.
- `haltId` and not stalled, no redirect: IF/ID <= bubble, drop any available or buffered instruction, go HALTED (DRAIN first if a response is in flight).
- PC arithmetic is 16-bit modulo: 16'hFFFE + 2 = 16'h0000.

## Timing
- Reset values:
  - pc = `RESET_PC`
  - `instrIfId` = `NOP_INSTR`
  - `pcPlus2IfId` = 0
  - `validIfId` = 0
  - state = REQ
  - buffer empty
  - `imemReq` = 0 while `rst` is high
- `imemReq` and `imemAddr` are combinational from state/pc. All other outputs are registered.
- Zero-latency memory: one instruction per cycle. IF/ID is valid 1 cycle after the first request.
- N-cycle memory: IF/ID is loaded on the edge ending the `imemDone` cycle. Next request issues the following cycle.
- Reset mid-request (WAIT/DRAIN): state returns to REQ. A stale `imemDone` arriving after reset release is the memory's responsibility; the memory is reset by the same `rst`.
- Redirect: first request to the target is in the cycle after redirect (REQ path), or the cycle after the drained `imemDone` (DRAIN path).

## Structure
- Package `fetch_pkg`:
  - state enum {REQ, WAIT, BUF, DRAIN, HALTED}
  - `NOP_INSTR`
  - `RESET_PC`
  - `INSTR_W` = 16
- Sub-module `ifid_reg`: IF/ID register with write-enable and flush inputs, async active-high reset to bubble. FSM, PC, and buffer stay in `fetch_stage`.

## Test plan
- Reset, memory returns done same cycle, mem[0]=16'h4001, mem[2]=16'h4102 -> `imemAddr` 0, 2, 4 on consecutive cycles. Cycle after first request: `instrIfId`=16'h4001, `pcPlus2IfId`=2, `validIfId`=1.
- One-cycle load-use stall (`writePc`=`writeIfId`=0) coinciding with done at addr 4 -> IF/ID unchanged, state BUF, `imemReq`=0. Next cycle unstalled: `instrIfId`=mem[4], next `imemAddr`=6. No instruction lost or duplicated.
- 3-cycle memory latency, `redirect`=1, `redirectPc`=16'h0041 in WAIT -> `validIfId`=0, `instrIfId`=16'h0800. In-flight response discarded. Next `imemAddr`=16'h0040.
- `redirect` and stall in the same cycle -> IF/ID flushed to bubble despite `writeIfId`=0. PC = target.
- `haltId`=1, unstalled -> `imemReq` stays 0 for 10 cycles, `validIfId`=0. Then redirect to 16'h0010 -> request at 16'h0010 next cycle.
- Async `rst` pulse mid-WAIT -> outputs immediately at reset values. After release, `imemAddr`=`RESET_PC` with `imemReq`=1.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned PC_W    = 16;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0800;
  localparam logic [PC_W-1:0]    RESET_PC  = 16'h0000;

  typedef enum logic [2:0] {
    REQ,
    WAIT,
    BUF,
    DRAIN,
    HALTED
  } fetchState_t;

  // Instructions are halfword aligned; the low address bit is never used.
  function automatic logic [PC_W-1:0] alignPc(input logic [PC_W-1:0] pc);
    return {pc[PC_W-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_stage_ifid.sv
// IF/ID pipeline register: flush to bubble takes priority over write-enable.
module ifid_reg
  import fetch_pkg::*;
#(
  parameter logic [INSTR_W-1:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               writeEn,
  input  logic               flush,
  input  logic [INSTR_W-1:0] instrIn,
  input  logic [PC_W-1:0]    pcPlus2In,
  input  logic               validIn,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pcPlus2,
  output logic               valid
);

  // A bubble keeps the previous pcPlus2 so decode sees a stable PC context.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr   <= NOP_INSTR;
      pcPlus2 <= '0;
      valid   <= 1'b0;
    end else if (flush) begin
      instr   <= NOP_INSTR;
      valid   <= 1'b0;
    end else if (writeEn) begin
      instr   <= instrIn;
      pcPlus2 <= pcPlus2In;
      valid   <= validIn;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, imem request handshake, one-entry skid buffer,
// redirect flush and halt handling, feeding the IF/ID register.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0]    RESET_PC  = fetch_pkg::RESET_PC,
  parameter logic [INSTR_W-1:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               writePc,
  input  logic               writeIfId,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirectPc,
  input  logic               haltId,
  output logic               imemReq,
  output logic [PC_W-1:0]    imemAddr,
  input  logic               imemDone,
  input  logic [INSTR_W-1:0] imemRdata,
  output logic [INSTR_W-1:0] instrIfId,
  output logic [PC_W-1:0]    pcPlus2IfId,
  output logic               validIfId
);

  fetchState_t        state;
  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    pcPlus2;
  logic [INSTR_W-1:0] bufData;
  logic [INSTR_W-1:0] availData;
  logic               stall;
  logic               inFlight;
  logic               pendingNoDone;
  logic               avail;
  logic               ifidLoad;
  logic               ifidFlush;

  assign stall         = !writePc || !writeIfId;
  assign inFlight      = (state == REQ) || (state == WAIT);
  assign pendingNoDone = inFlight && !imemDone;
  assign avail         = (inFlight && imemDone) || (state == BUF);
  assign availData     = (state == BUF) ? bufData : imemRdata;
  assign pcPlus2       = pc + PC_W'(2);

  // IF/ID takes a real instruction only when nothing overrides it; any
  // unstalled cycle without one (and every redirect) writes a bubble.
  assign ifidLoad  = !redirect && !stall && !haltId && avail;
  assign ifidFlush = redirect || (!stall && !ifidLoad);

  assign imemReq  = !rst && (state == REQ);
  assign imemAddr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= REQ;
      pc      <= RESET_PC;
      bufData <= '0;
    end else if (redirect) begin
      pc    <= alignPc(redirectPc);
      state <= pendingNoDone ? DRAIN : REQ;
    end else begin
      unique case (state)
        REQ, WAIT, BUF: begin
          if (!stall && haltId) begin
            state <= pendingNoDone ? DRAIN : HALTED;
          end else if (avail) begin
            if (!stall) begin
              pc    <= pcPlus2;
              state <= REQ;
            end else if (state != BUF) begin
              bufData <= imemRdata;
              state   <= BUF;
            end
          end else begin
            state <= WAIT;
          end
        end
        // haltId is held by decode, so it is still visible once the drain ends.
        DRAIN: begin
          if (imemDone) begin
            state <= (haltId && !stall) ? HALTED : REQ;
          end
        end
        HALTED:  state <= HALTED;
        default: state <= REQ;
      endcase
    end
  end

  ifid_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) uIfid (
    .clk      (clk),
    .rst      (rst),
    .writeEn  (ifidLoad),
    .flush    (ifidFlush),
    .instrIn  (availData),
    .pcPlus2In(pcPlus2),
    .validIn  (1'b1),
    .instr    (instrIfId),
    .pcPlus2  (pcPlus2IfId),
    .valid    (validIfId)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage with a variable-latency instruction memory.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        writePc, writeIfId, redirect, haltId;
  logic [15:0] redirectPc;
  logic        imemReq, imemDone;
  logic [15:0] imemAddr, imemRdata;
  logic [15:0] instrIfId, pcPlus2IfId;
  logic        validIfId;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [256];
  int          lat = 0;
  logic        pending;
  int          cnt;
  logic [15:0] pAddr;
  logic [15:0] rdAddr;
  logic        loadEdge = 1'b0;
  logic [31:0] expQ [$];

  fetch_stage dut (
    .clk        (clk),
    .rst        (rst),
    .writePc    (writePc),
    .writeIfId  (writeIfId),
    .redirect   (redirect),
    .redirectPc (redirectPc),
    .haltId     (haltId),
    .imemReq    (imemReq),
    .imemAddr   (imemAddr),
    .imemDone   (imemDone),
    .imemRdata  (imemRdata),
    .instrIfId  (instrIfId),
    .pcPlus2IfId(pcPlus2IfId),
    .validIfId  (validIfId)
  );

  always #5 clk = ~clk;

  // Memory: latency 0 answers in the request cycle, latency N answers N cycles later.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 1'b0;
      cnt     <= 0;
      pAddr   <= '0;
    end else if (lat != 0) begin
      if (!pending && imemReq) begin
        pending <= 1'b1;
        cnt     <= lat;
        pAddr   <= imemAddr;
      end else if (pending) begin
        if (cnt == 1) pending <= 1'b0;
        else          cnt     <= cnt - 1;
      end
    end
  end

  always_comb begin
    rdAddr    = (lat == 0) ? imemAddr : pAddr;
    imemRdata = mem[rdAddr[8:1]];
    imemDone  = (lat == 0) ? imemReq : (pending && cnt == 1);
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: a valid IF/ID after an unstalled, unredirected edge is a fresh load.
  always @(posedge clk) loadEdge <= writePc && writeIfId && !redirect && !rst;

  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (validIfId === 1'b1 && loadEdge) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected got %h/%h want none", instrIfId, pcPlus2IfId);
        end else begin
          e = expQ.pop_front();
          chk("sb_instr", instrIfId, e[31:16]);
          chk("sb_pcplus2", pcPlus2IfId, e[15:0]);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'hC000 | 16'(i);
    mem[0] = 16'h4001;
    mem[1] = 16'h4102;
    rst = 1'b1; writePc = 1'b1; writeIfId = 1'b1; redirect = 1'b0;
    haltId = 1'b0; redirectPc = '0;
    repeat (2) @(negedge clk);
    chk("rst_req", 16'(imemReq), 16'd0);
    chk("rst_valid", 16'(validIfId), 16'd0);
    chk("rst_instr", instrIfId, 16'h0800);
    chk("rst_pcplus2", pcPlus2IfId, 16'h0000);
    rst = 1'b0;
    expQ.push_back({16'h4001, 16'h0002});
    expQ.push_back({16'h4102, 16'h0004});
    expQ.push_back({16'hC002, 16'h0006});
    #1;
    chk("first_req", 16'(imemReq), 16'd1);
    chk("first_addr", imemAddr, 16'h0000);
    @(negedge clk);
    chk("addr2", imemAddr, 16'h0002);
    chk("first_valid", 16'(validIfId), 16'd1);
    @(negedge clk);
    chk("addr4", imemAddr, 16'h0004);
    writePc = 1'b0; writeIfId = 1'b0;
    @(negedge clk);
    chk("buf_req", 16'(imemReq), 16'd0);
    chk("buf_hold_instr", instrIfId, 16'h4102);
    chk("buf_hold_pc", pcPlus2IfId, 16'h0004);
    writePc = 1'b1; writeIfId = 1'b1;
    @(negedge clk);
    chk("after_buf_addr", imemAddr, 16'h0006);
    chk("after_buf_req", 16'(imemReq), 16'd1);
    lat = 3;
    @(negedge clk);
    chk("wait_req", 16'(imemReq), 16'd0);
    chk("wait_valid", 16'(validIfId), 16'd0);
    redirect = 1'b1; redirectPc = 16'h0041;
    @(negedge clk);
    redirect = 1'b0;
    chk("redir_valid", 16'(validIfId), 16'd0);
    chk("redir_instr", instrIfId, 16'h0800);
    chk("drain_req", 16'(imemReq), 16'd0);
    @(negedge clk);
    chk("drain_req2", 16'(imemReq), 16'd0);
    @(negedge clk);
    chk("redir_addr", imemAddr, 16'h0040);
    chk("redir_req", 16'(imemReq), 16'd1);
    lat = 0;
    expQ.push_back({16'hC020, 16'h0042});
    @(negedge clk);
    chk("addr42", imemAddr, 16'h0042);
    redirect = 1'b1; redirectPc = 16'h0080; writePc = 1'b0; writeIfId = 1'b0;
    @(negedge clk);
    redirect = 1'b0; writePc = 1'b1; writeIfId = 1'b1;
    chk("rs_valid", 16'(validIfId), 16'd0);
    chk("rs_instr", instrIfId, 16'h0800);
    chk("rs_addr", imemAddr, 16'h0080);
    expQ.push_back({16'hC040, 16'h0082});
    @(negedge clk);
    chk("addr82", imemAddr, 16'h0082);
    haltId = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("halt_req", 16'(imemReq), 16'd0);
      chk("halt_valid", 16'(validIfId), 16'd0);
    end
    haltId = 1'b0; redirect = 1'b1; redirectPc = 16'h0010;
    @(negedge clk);
    redirect = 1'b0;
    chk("unhalt_req", 16'(imemReq), 16'd1);
    chk("unhalt_addr", imemAddr, 16'h0010);
    expQ.push_back({16'hC008, 16'h0012});
    @(negedge clk);
    chk("addr12", imemAddr, 16'h0012);
    redirect = 1'b1; redirectPc = 16'hFFFF;
    @(negedge clk);
    redirect = 1'b0;
    chk("wrap_addr", imemAddr, 16'hFFFE);
    expQ.push_back({16'hC0FF, 16'h0000});
    @(negedge clk);
    chk("wrap_next", imemAddr, 16'h0000);
    lat = 3;
    @(negedge clk);
    chk("wait2_req", 16'(imemReq), 16'd0);
    #2 rst = 1'b1;
    #1;
    chk("async_valid", 16'(validIfId), 16'd0);
    chk("async_instr", instrIfId, 16'h0800);
    chk("async_pcplus2", pcPlus2IfId, 16'h0000);
    chk("async_addr", imemAddr, 16'h0000);
    chk("async_req", 16'(imemReq), 16'd0);
    @(negedge clk);
    lat = 0;
    rst = 1'b0;
    expQ.push_back({16'h4001, 16'h0002});
    #1;
    chk("rel_req", 16'(imemReq), 16'd1);
    chk("rel_addr", imemAddr, 16'h0000);
    @(negedge clk);
    chk("rel_addr2", imemAddr, 16'h0002);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("sb_left", 16'(expQ.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
